// File: rtl/ifid_queue_if.sv
// Fetch-to-decode instruction queue bundle: fetch push side, decode pop side, occupancy.
// The queue itself uses the slave view; the fetch/decode environment uses the master view.
interface ifid_queue_if #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_ins;
  logic             in_adel;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_ins;
  logic             out_adel;
  logic             out_in_ds;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_ins, in_adel, out_ready,
    input  in_ready, out_valid, out_pc, out_ins, out_adel, out_in_ds, count
  );

  modport slave (
    input  in_valid, in_pc, in_ins, in_adel, out_ready,
    output in_ready, out_valid, out_pc, out_ins, out_adel, out_in_ds, count
  );
endinterface

// File: rtl/ifid_queue.sv
// Show-ahead instruction queue between fetch and decode, with branch-delay-slot tagging
// of the issued instruction and a single-cycle flush.
module ifid_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  ifid_queue_if.slave  q
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ds_q, ds_d;

  logic   full_s, empty_s, push_s, pop_s;
  entry_t head_s;

  // REGIMM is a branch regardless of rt; JR/JALR share funct[5:1].
  function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
    logic br;
    br = 1'b0;
    case (op)
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: br = 1'b1;
      6'b000000: begin
        case (funct)
          6'b001000, 6'b001001: br = 1'b1;
          default:              br = 1'b0;
        endcase
      end
      default: br = 1'b0;
    endcase
    return br;
  endfunction

  assign full_s  = (cnt_q == FULL_CNT);
  assign empty_s = (cnt_q == {(PTR_W+1){1'b0}});
  assign push_s  = q.in_valid & ~full_s & ~flush;
  assign pop_s   = q.out_ready & ~empty_s & ~flush;
  assign head_s  = mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ds_d  = ds_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ds_d  = 1'b0;
    end else begin
      if (push_s) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + PTR_ONE;
        ds_d = is_branch(head_s.ins[31:26], head_s.ins[5:0]);
      end else begin
        rd_d = rd_q;
        ds_d = ds_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ds_q  <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ds_q  <= ds_d;
    end
  end

  // Storage needs no reset: every read is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_q] <= '{pc: q.in_pc, ins: q.in_ins, adel: q.in_adel};
    end
  end

  always_comb begin
    q.in_ready  = ~full_s;
    q.out_valid = ~empty_s;
    q.count     = cnt_q;
    if (empty_s) begin
      q.out_pc    = 32'h0000_0000;
      q.out_ins   = 32'h0000_0000;
      q.out_adel  = 1'b0;
      q.out_in_ds = 1'b0;
    end else begin
      q.out_pc    = head_s.pc;
      q.out_ins   = head_s.ins;
      q.out_adel  = head_s.adel;
      q.out_in_ds = ds_q;
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// Directed and randomized bench for ifid_queue against a queue-based reference model.
module tb_ifid_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  ifid_queue_if #(.DEPTH(DEPTH)) bus ();

  ifid_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus)
  );

  always #5 clk = ~clk;

  ent_t mq[$];
  bit   ds_m = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam logic [31:0] ADDU = 32'h0022_1821;
  localparam logic [31:0] JR   = 32'h03E0_0008;

  logic [31:0] ins_tab [8] = '{32'h1022_0003, 32'h0022_1821, 32'h03E0_0008, 32'h0040_F809,
                               32'h0800_0010, 32'h0411_0001, 32'h0000_000A, 32'h2408_0001};

  function automatic bit model_branch(input logic [31:0] ins);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic adel, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_ins    = ins;
    bus.in_adel   = adel;
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  // One clock: predict the model's transfer from pre-edge state, then advance it.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    push = bus.in_valid && (mq.size() < DEPTH) && !flush;
    pop  = bus.out_ready && (mq.size() > 0) && !flush;
    e    = '{pc: bus.in_pc, ins: bus.in_ins, adel: bus.in_adel};
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      ds_m = 1'b0;
    end else begin
      if (pop) begin
        ds_m = model_branch(mq[0].ins);
        void'(mq.pop_front());
      end
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic check_model(input string ph);
    bit ne;
    ne = (mq.size() > 0);
    chk({ph, ".count"},     32'(bus.count),     32'(mq.size()));
    chk({ph, ".in_ready"},  32'(bus.in_ready),  32'(mq.size() < DEPTH));
    chk({ph, ".out_valid"}, 32'(bus.out_valid), 32'(ne));
    chk({ph, ".out_pc"},    bus.out_pc,         ne ? mq[0].pc : 32'h0);
    chk({ph, ".out_ins"},   bus.out_ins,        ne ? mq[0].ins : 32'h0);
    chk({ph, ".out_adel"},  32'(bus.out_adel),  ne ? 32'(mq[0].adel) : 32'h0);
    chk({ph, ".out_in_ds"}, 32'(bus.out_in_ds), 32'(ds_m && ne));
  endtask

  initial begin
    logic [31:0] ds_exp [3] = '{32'h0, 32'h1, 32'h0};
    logic [31:0] br_tab [2] = '{BEQ, JR};

    // reset held two cycles with fetch presenting
    drv(1'b1, 32'hBFC0_0000, ADDU, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    cycle();
    check_model("reset");
    chk("reset.out_ins", bus.out_ins, 32'h0);
    rst = 1'b0;

    // fill to full
    for (int i = 0; i < DEPTH; i++) begin
      drv(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      cycle();
      check_model("fill");
    end
    chk("full.count", 32'(bus.count), 32'd4);
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    drv(1'b1, 32'hBFC0_0010, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("fifth.count", 32'(bus.count), 32'd4);
    chk("fifth.head", bus.out_pc, 32'hBFC0_0000);
    for (int i = 0; i < DEPTH; i++) begin
      drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("drain.pc", bus.out_pc, 32'hBFC0_0000 + 32'(4 * i));
      cycle();
      check_model("drain");
    end
    chk("drain.count", 32'(bus.count), 32'd0);

    // steady push+pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'h0000_1000 + 32'(4 * i), ADDU, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 32'h0000_2000 + 32'(4 * i), ADDU, 1'b0, 1'b1, 1'b0);
      cycle();
      chk("conc.count", 32'(bus.count), 32'd2);
      check_model("conc");
    end
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    cycle();
    check_model("conc_drain");

    // delay-slot tagging after BEQ, then after JR
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        drv(1'b1, 32'h0000_3000 + 32'(4 * i), (i == 0) ? br_tab[b] : ADDU, 1'b0, 1'b0, 1'b0);
        cycle();
      end
      for (int i = 0; i < 3; i++) begin
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("ds.in_ds", 32'(bus.out_in_ds), ds_exp[i]);
        cycle();
      end
    end

    // flush right after a branch pop
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'h0000_4000 + 32'(4 * i), (i == 0) ? BEQ : ADDU, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("preflush.count", 32'(bus.count), 32'd3);
    chk("preflush.in_ds", 32'(bus.out_in_ds), 32'd1);
    drv(1'b1, 32'h0000_5000, ADDU, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("flush.count", 32'(bus.count), 32'd0);
    chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
    drv(1'b1, 32'h0000_5004, ADDU, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("postflush.valid", 32'(bus.out_valid), 32'd1);
    chk("postflush.in_ds", 32'(bus.out_in_ds), 32'd0);

    // address-error entry passes through untouched
    drv(1'b1, 32'hBFC0_0002, ADDU, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("adel.flag", 32'(bus.out_adel), 32'd1);
    chk("adel.pc", bus.out_pc, 32'hBFC0_0002);
    check_model("adel");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom, ins_tab[$urandom_range(0, 7)],
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 29) == 0));
      cycle();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Instruction queue between the fetch stage and the ID-stage decoder. Buffers fetched instructions, each with its PC and fetch address-error flag, in a small show-ahead FIFO so that fetch and decode can stall independently. For every instruction it issues, it also produces the branch-delay-slot flag that decode and exception handling need. A flush from the exception/redirect logic empties the queue in one cycle.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥2
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and delay-slot tracking this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; equals !full
- in_pc  in  32  PC of fetched instruction
- in_ins  in  32  fetched instruction word
- in_adel  in  1  fetch address error (misaligned PC)
- out_valid  out  1  head entry present; equals !empty
- out_ready  in  1  ID consumes the head entry this cycle
- out_pc  out  32  head PC; 0 when empty
- out_ins  out  32  head instruction; 32'h0 (NOP) when empty
- out_adel  out  1  head address-error flag; 0 when empty
- out_in_ds  out  1  head instruction is in a branch delay slot
- count  out  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc, ins, adel}; read pointer rd_ptr, write pointer wr_ptr, occupancy cnt. Pointers wrap modulo DEPTH.
- push = in_valid & in_ready & !flush. Writes the entry at wr_ptr; wr_ptr+1.
- pop = out_valid & out_ready & !flush. rd_ptr+1.
- cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full when cnt==DEPTH; empty when cnt==0. No push when full, even if a pop occurs the same cycle: in_ready depends only on registered cnt.
- Outputs are show-ahead and combinational from storage[rd_ptr], forced to zero when empty. No empty-bypass: a pushed entry first appears on the following cycle.
- Delay-slot tracking: register ds_pending.
  - On pop, ds_pending <= is_branch(out_ins); otherwise it holds.
  - out_in_ds = ds_pending & out_valid.
  - is_branch is true for:
    - op 000010 J, 000011 JAL, 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ, 000001 REGIMM (BLTZ/BGEZ/BLTZAL/BGEZAL, regardless of rt)
    - op 000000 with funct 001000 JR or 001001 JALR
- Flush: rd_ptr, wr_ptr, cnt and ds_pending clear to 0 at the edge. A push or pop in the same cycle is ignored.
- Reset: same state as flush. Storage contents are don't-care because outputs are masked when empty.
- Priority: rst > flush > push/pop.
- in_adel entries are queued and popped like normal entries. The queue does not interpret them.

## Timing
- Reset values: in_ready=1, out_valid=0, out_pc=0, out_ins=0, out_adel=0, out_in_ds=0, count=0.
- Push latency: an entry accepted at edge N drives out_* from cycle N+1.
- Pop: out_* change to the next entry (or zero) in the cycle after the accepting edge.
- in_ready rises the cycle after the first pop from full. out_valid falls the cycle after the last pop.
- After flush at edge N: cycle N+1 has count=0, in_ready=1, out_valid=0, out_in_ds=0.
- Wrap-around: after DEPTH pushes and pops, the pointers return to 0 with no loss or reordering.
- A branch popped immediately before a flush does not mark the next instruction as a delay slot.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 → count=0, in_ready=1, out_valid=0, out_ins=0, out_in_ds=0.
- Fill/full: push PCs 0xBFC00000..0xBFC0000C with out_ready=0 → count=4, in_ready=0. A 5th in_valid is not accepted. Then pop 4 times → PCs come out in order and count returns to 0.
- Concurrent push/pop at count=2 for 10 cycles → count stays 2, order preserved across pointer wrap.
- Delay slot: push BEQ (0x10220003), ADDU (0x00221821), ADDU; pop all → out_in_ds = 0, 1, 0. Repeat with JR (0x03E00008) → 0, 1, 0.
- Flush: count=3, flush=1 with in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0. The next push appears with out_in_ds=0, even if a branch was popped the cycle before the flush.
- Address error: push in_pc=0xBFC00002, in_adel=1 → out_adel=1 and out_pc=0xBFC00002 on the next cycle.
